sram_req_arb: RTL and testbench
===============================

SRAM_REQ_ARB -- requirements
Module: sram_req_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the maximum number of accepted-but-unanswered transactions (power of two, 2..8).
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive data grants allowed while inst waits.
REQ-003 SHALL have ports:
- aclk  in  1  sole clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- inst_sram_req / inst_sram_wr  in  1  inst master request / write.
- inst_sram_size  in  2  byte-count code.
- inst_sram_addr  in  32  address.
- inst_sram_wstrb  in  4  byte strobes.
- inst_sram_wdata  in  32  write data.
- inst_sram_addr_ok / inst_sram_data_ok  out  1  request accepted / response done.
- inst_sram_rdata  out  32  read data.
- data_sram_*  same set, widths and directions as inst_sram_*  data master.
- slv_req / slv_wr  out  1  shared downstream request / write.
- slv_size  out  2  selected size.
- slv_addr  out  32  selected address.
- slv_wstrb  out  4  selected strobes.
- slv_wdata  out  32  selected write data.
- slv_addr_ok / slv_data_ok  in  1  downstream accept / response.
- slv_rdata  in  32  downstream read data.
- err_unexp  out  1  sticky flag: slv_data_ok arrived with nothing outstanding.

Function
REQ-004 SHALL arbitrate two SRAM-like masters (inst, data) onto one SRAM-like slave port.
REQ-005 SHALL use fixed priority data > inst, unless the starvation counter equals STARVE_MAX while inst_sram_req is high; then inst SHALL win.
REQ-006 Starvation counter SHALL increment on each data grant accepted (slv_addr_ok) while inst_sram_req is high, saturating at STARVE_MAX.
REQ-007 Starvation counter SHALL clear on any inst acceptance, and whenever inst_sram_req is low.
REQ-008 Grant SHALL be locked: once slv_req is high without slv_addr_ok, the same master SHALL stay selected until its acceptance, even if the other master raises req.
REQ-009 slv_* request fields SHALL be a combinational mux of the granted master; slv_req = granted master's req AND NOT full.
REQ-010 Master addr_ok SHALL equal slv_addr_ok AND slv_req AND (grant == that master); the non-granted master's addr_ok SHALL be 0.
REQ-011 On each acceptance, the owner bit (0=inst, 1=data) SHALL be pushed into an in-order tag FIFO of DEPTH entries.
REQ-012 On slv_data_ok with the FIFO non-empty, the head SHALL be popped and data_ok driven to that owner only, in the same cycle (zero added latency).
REQ-013 inst_sram_rdata and data_sram_rdata SHALL both be driven directly from slv_rdata.
REQ-014 FIFO full (count == DEPTH) SHALL force slv_req = 0 and both addr_ok = 0; a pop in the same cycle SHALL NOT unblock the push (no bypass).
REQ-015 Simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-016 Pointers SHALL wrap modulo DEPTH; the count SHALL be log2(DEPTH)+1 bits wide.
REQ-017 slv_data_ok with an empty FIFO SHALL assert no master data_ok, SHALL set err_unexp, and SHALL NOT change the FIFO.
REQ-018 Grant FSM SHALL have states IDLE, LOCK_INST and LOCK_DATA:
- IDLE -> LOCK_x when slv_req is high without slv_addr_ok.
- LOCK_x -> IDLE on acceptance.

Reset
REQ-019 Under areset, the following SHALL clear on the next edge: FSM to IDLE, FIFO pointers and count 0, starvation counter 0, err_unexp 0.
REQ-020 During and after reset, all addr_ok and data_ok outputs SHALL be 0 until a new handshake; a reset mid-transaction SHALL discard every outstanding tag.
REQ-021 err_unexp SHALL clear only on areset.

Structure
REQ-022 Shared package SHALL hold: owner encoding (OWN_INST=0, OWN_DATA=1), FSM state encodings, and the SRAM size codes.
REQ-023 The tag FIFO SHALL be a sub-module, tag_fifo (1-bit data, parameter DEPTH, push/pop/full/empty/count).

Verification
REQ-024 Bench SHALL cover these directed scenarios:
- inst and data req together, slv_addr_ok=1 every cycle, slv_data_ok 2 cycles later -> data accepted first; data_sram_data_ok precedes inst_sram_data_ok.
- data req held continuously, inst held, all accepted immediately -> after 4 data grants inst gets 1 grant; then the counter restarts at 0.
- slv_addr_ok held low 3 cycles with inst granted, data raises req in cycle 1 -> slv_addr stays inst_sram_addr until acceptance.
- 4 accepts, no data_ok -> count=4, slv_req=0; 5th request stalls until one data_ok, then is accepted on the following cycle.
- push and pop in the same cycle at count=2 -> count stays 2; response owners match issue order (e.g. D,I,D).
- slv_data_ok pulse after reset with nothing outstanding -> no data_ok, err_unexp=1 and stays 1; areset clears it.

Source files
------------

// File: rtl/sram_req_arb_pkg.sv
// Shared encodings for the two-master SRAM request arbiter: response owner tags,
// grant FSM states and SRAM size codes.
package sram_req_arb_pkg;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOCK_INST = 2'd1,
        ST_LOCK_DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_req_arb_tag_fifo.sv
// In-order owner-tag FIFO: head visible combinationally, push/pop take effect next edge.
// Push is ignored when full and pop when empty; no bypass between the two.
module tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     i_push,
    input  logic                     i_push_dat,
    input  logic                     i_pop,
    output logic                     o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_push_dat;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/sram_req_arb.sv
// Arbitrates inst/data SRAM masters onto one slave: combinational request mux, zero-latency
// response routing via owner-tag FIFO; backpressure = slave addr_ok, plus a hard stall when DEPTH are outstanding.
module sram_req_arb
    import sram_req_arb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        slv_req,
    output logic        slv_wr,
    output logic [1:0]  slv_size,
    output logic [31:0] slv_addr,
    output logic [3:0]  slv_wstrb,
    output logic [31:0] slv_wdata,
    input  logic        slv_addr_ok,
    input  logic        slv_data_ok,
    input  logic [31:0] slv_rdata,
    output logic        err_unexp
);

    localparam int              CW         = $clog2(STARVE_MAX + 1);
    localparam int              SW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   STARVE_LIM = CW'(STARVE_MAX);
    localparam logic [SW-1:0]   FULL_CNT   = SW'(DEPTH);

    arb_state_t    r_state;
    logic [CW-1:0] r_starve;
    logic          r_err;

    logic          w_grant;
    logic          w_gnt_req;
    logic          w_acc;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_head;
    logic [SW-1:0] w_count;

    // A locked grant holds until accepted; otherwise data wins unless inst has starved.
    always_comb begin
        w_grant = OWN_INST;
        case (r_state)
            ST_LOCK_INST: w_grant = OWN_INST;
            ST_LOCK_DATA: w_grant = OWN_DATA;
            default: begin
                if (inst_sram_req && (r_starve == STARVE_LIM)) begin
                    w_grant = OWN_INST;
                end else if (data_sram_req) begin
                    w_grant = OWN_DATA;
                end else begin
                    w_grant = OWN_INST;
                end
            end
        endcase
    end

    assign w_gnt_req = (w_grant == OWN_DATA) ? data_sram_req : inst_sram_req;
    assign slv_req   = w_gnt_req & ~w_full & ~areset;
    assign slv_wr    = (w_grant == OWN_DATA) ? data_sram_wr    : inst_sram_wr;
    assign slv_size  = (w_grant == OWN_DATA) ? data_sram_size  : inst_sram_size;
    assign slv_addr  = (w_grant == OWN_DATA) ? data_sram_addr  : inst_sram_addr;
    assign slv_wstrb = (w_grant == OWN_DATA) ? data_sram_wstrb : inst_sram_wstrb;
    assign slv_wdata = (w_grant == OWN_DATA) ? data_sram_wdata : inst_sram_wdata;

    assign w_acc             = slv_req & slv_addr_ok;
    assign inst_sram_addr_ok = w_acc & (w_grant == OWN_INST);
    assign data_sram_addr_ok = w_acc & (w_grant == OWN_DATA);

    assign w_pop             = slv_data_ok & ~w_empty & ~areset;
    assign inst_sram_data_ok = w_pop & (w_head == OWN_INST);
    assign data_sram_data_ok = w_pop & (w_head == OWN_DATA);
    assign inst_sram_rdata   = slv_rdata;
    assign data_sram_rdata   = slv_rdata;
    assign err_unexp         = r_err;

    tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .aclk       (aclk),
        .areset     (areset),
        .i_push     (w_acc),
        .i_push_dat (w_grant),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state  <= ST_IDLE;
            r_starve <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (slv_req && !slv_addr_ok) begin
                        r_state <= (w_grant == OWN_DATA) ? ST_LOCK_DATA : ST_LOCK_INST;
                    end
                end
                ST_LOCK_INST, ST_LOCK_DATA: begin
                    if (w_acc) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (!inst_sram_req || (w_acc && (w_grant == OWN_INST))) begin
                r_starve <= '0;
            end else if (w_acc && (r_starve != STARVE_LIM)) begin
                r_starve <= r_starve + CW'(1);
            end

            if (slv_data_ok && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    a_full_matches_count: assert property (@(posedge aclk) disable iff (areset)
        (w_full == (w_count == FULL_CNT)));

endmodule

// File: tb/tb_sram_req_arb.sv
// Randomized and directed bench for sram_req_arb: a transaction-level model predicts grants,
// and a decoupled monitor checks response routing against a queue of expected owners.
module tb_sram_req_arb;
    import sram_req_arb_pkg::*;

    localparam int DEPTH = 4;
    localparam int SM    = 4;

    logic        aclk = 1'b0;
    logic        areset;
    logic        inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic [3:0]  inst_sram_wstrb;
    logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic [3:0]  data_sram_wstrb;
    logic        slv_req, slv_wr, slv_addr_ok, slv_data_ok, err_unexp;
    logic [1:0]  slv_size;
    logic [31:0] slv_addr, slv_wdata, slv_rdata;
    logic [3:0]  slv_wstrb;

    always #5 aclk = ~aclk;

    sram_req_arb #(.DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
        .aclk              (aclk),
        .areset            (areset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .slv_req           (slv_req),
        .slv_wr            (slv_wr),
        .slv_size          (slv_size),
        .slv_addr          (slv_addr),
        .slv_wstrb         (slv_wstrb),
        .slv_wdata         (slv_wdata),
        .slv_addr_ok       (slv_addr_ok),
        .slv_data_ok       (slv_data_ok),
        .slv_rdata         (slv_rdata),
        .err_unexp         (err_unexp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Stimulus knobs
    int p_req = 0, p_aok = 0, p_dok = 100;
    int lat_min = 1, lat_max = 1;
    int i_left = 0, d_left = 0;
    bit force_dok = 0, sl_hold = 0;

    // Master/slave agent state
    bit          i_pend = 0, d_pend = 0;
    int          sl_q[$];
    logic [31:0] rd_drv;
    int          cyc = 0;

    // Reference model state
    int m_lock = -1, m_starve = 0, m_cnt = 0;
    bit m_err = 0;
    bit exp_q[$];
    int acc_log[$], acc_cyc[$], dok_log[$];
    int last_pop_cyc = -100;

    task automatic drive();
        if (areset) begin
            i_pend = 0;
            d_pend = 0;
        end else begin
            if (!i_pend && i_left > 0 && $urandom_range(99) < p_req) begin
                i_pend = 1; i_left--;
                inst_sram_wr    = 1'($urandom_range(1));
                inst_sram_size  = 2'($urandom_range(2));
                inst_sram_addr  = $urandom;
                inst_sram_wstrb = 4'($urandom);
                inst_sram_wdata = $urandom;
            end
            if (!d_pend && d_left > 0 && $urandom_range(99) < p_req) begin
                d_pend = 1; d_left--;
                data_sram_wr    = 1'($urandom_range(1));
                data_sram_size  = 2'($urandom_range(2));
                data_sram_addr  = $urandom;
                data_sram_wstrb = 4'($urandom);
                data_sram_wdata = $urandom;
            end
        end
        inst_sram_req = i_pend;
        data_sram_req = d_pend;
        slv_addr_ok   = ($urandom_range(99) < p_aok);
        slv_data_ok   = 1'b0;
        if (force_dok) begin
            slv_data_ok = 1'b1;
        end else if (!sl_hold && sl_q.size() > 0 && $urandom_range(99) < p_dok) begin
            if (sl_q[0] <= cyc) begin
                slv_data_ok = 1'b1;
                void'(sl_q.pop_front());
            end
        end
        rd_drv    = $urandom;
        slv_rdata = rd_drv;
    endtask

    // Predicts the slave-side view of this cycle from the arbitration rules, then advances the model.
    task automatic check_cycle();
        int g;
        bit full, ereq, acc;
        chk("fifo_count", 64'(dut.u_tag_fifo.o_count), 64'(m_cnt));
        chk("err_unexp", err_unexp, m_err);
        full = (m_cnt == DEPTH);
        if (m_lock >= 0)                          g = m_lock;
        else if (inst_sram_req && m_starve == SM) g = 0;
        else if (data_sram_req)                   g = 1;
        else                                      g = 0;
        ereq = !areset && !full && (g == 1 ? data_sram_req : inst_sram_req);
        chk("slv_req", slv_req, ereq);
        if (ereq) begin
            chk("slv_fields", {slv_wr, slv_size, slv_wstrb, slv_addr},
                g == 1 ? {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr}
                       : {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr});
            chk("slv_wdata", slv_wdata, g == 1 ? data_sram_wdata : inst_sram_wdata);
        end
        acc = ereq && slv_addr_ok;
        chk("addr_ok", {inst_sram_addr_ok, data_sram_addr_ok}, {acc && g == 0, acc && g == 1});
        if (areset) begin
            m_lock = -1; m_starve = 0; m_cnt = 0; m_err = 0;
            exp_q.delete();
            sl_q.delete();
            return;
        end
        if (acc) begin
            exp_q.push_back(1'(g));
            acc_log.push_back(g);
            acc_cyc.push_back(cyc);
            sl_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            if (g == 0) i_pend = 0;
            else        d_pend = 0;
        end
        if (slv_data_ok) begin
            if (m_cnt > 0) begin
                m_cnt--;
                last_pop_cyc = cyc;
            end else begin
                m_err = 1;
            end
        end
        if (acc) m_cnt++;
        if (ereq && !slv_addr_ok) m_lock = g;
        else if (acc)             m_lock = -1;
        if (!inst_sram_req || (acc && g == 0)) m_starve = 0;
        else if (acc && g == 1 && m_starve < SM) m_starve++;
    endtask

    task automatic step();
        drive();
        @(negedge aclk);
        check_cycle();
        @(posedge aclk);
        cyc++;
        #1;
    endtask

    // Response monitor: routes each slave response to the owner expected in issue order.
    initial begin
        bit o;
        forever begin
            @(negedge aclk);
            if (data_sram_data_ok)      dok_log.push_back(1);
            else if (inst_sram_data_ok) dok_log.push_back(0);
            if (slv_data_ok && !areset && exp_q.size() > 0) begin
                o = exp_q.pop_front();
                chk("data_ok_owner", {inst_sram_data_ok, data_sram_data_ok}, {o == 1'b0, o == 1'b1});
                chk("rdata", o ? data_sram_rdata : inst_sram_rdata, rd_drv);
            end else if (slv_data_ok || inst_sram_data_ok || data_sram_data_ok) begin
                chk("data_ok_spurious", {inst_sram_data_ok, data_sram_data_ok}, 2'b00);
            end
        end
    end

    initial begin
        int pat[10];
        pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        areset = 1'b1;
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = SZ_WORD; inst_sram_addr = 0;
        inst_sram_wstrb = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = SZ_WORD; data_sram_addr = 0;
        data_sram_wstrb = 0; data_sram_wdata = 0;
        slv_addr_ok = 0; slv_data_ok = 0; slv_rdata = 0;
        @(posedge aclk); #1;
        step(); step();
        areset = 1'b0;
        chk("reset_err", err_unexp, 1'b0);
        chk("reset_count", 64'(dut.u_tag_fifo.o_count), 64'd0);

        // Both masters together: data accepted first and answered first.
        p_req = 100; p_aok = 100; lat_min = 2; lat_max = 2;
        i_left = 1; d_left = 1;
        acc_log.delete(); dok_log.delete();
        repeat (8) step();
        chk("s1_n_resp", 64'(dok_log.size()), 64'd2);
        if (dok_log.size() >= 2) begin
            chk("s1_first_resp_data", 64'(dok_log[0]), 64'd1);
            chk("s1_second_resp_inst", 64'(dok_log[1]), 64'd0);
        end

        // Starvation: 4 data grants then 1 inst grant, repeating.
        lat_min = 1; lat_max = 1; i_left = 3; d_left = 12;
        acc_log.delete();
        repeat (20) step();
        chk("s2_n_acc", 64'(acc_log.size()), 64'd15);
        if (acc_log.size() >= 10)
            for (int i = 0; i < 10; i++) chk($sformatf("s2_grant_%0d", i), 64'(acc_log[i]), 64'(pat[i]));

        // Grant lock: inst stalls 3 cycles while data raises req.
        acc_log.delete();
        p_aok = 0; i_left = 1; d_left = 0;
        step();
        d_left = 1;
        step(); step();
        p_aok = 100;
        repeat (6) step();
        chk("s3_n_acc", 64'(acc_log.size()), 64'd2);
        if (acc_log.size() >= 2) begin
            chk("s3_locked_inst_first", 64'(acc_log[0]), 64'd0);
            chk("s3_data_second", 64'(acc_log[1]), 64'd1);
        end

        // Full FIFO: 4 accepted, fifth waits for a response and goes one cycle later.
        acc_log.delete(); acc_cyc.delete();
        sl_hold = 1; i_left = 3; d_left = 2;
        repeat (8) step();
        chk("s4_accepts_at_full", 64'(acc_log.size()), 64'd4);
        chk("s4_count_full", 64'(dut.u_tag_fifo.o_count), 64'd4);
        sl_hold = 0;
        step();
        sl_hold = 1;
        repeat (3) step();
        chk("s4_n_acc", 64'(acc_log.size()), 64'd5);
        if (acc_cyc.size() >= 5) chk("s4_fifth_after_pop", 64'(acc_cyc[4] - last_pop_cyc), 64'd1);
        sl_hold = 0;
        repeat (10) step();

        // Push and pop together at count 2; responses follow issue order.
        acc_log.delete(); dok_log.delete();
        lat_min = 2; lat_max = 2; i_left = 1; d_left = 2;
        step(); step(); step();
        chk("s5_count_steady", 64'(dut.u_tag_fifo.o_count), 64'd2);
        repeat (8) step();
        chk("s5_n_resp", 64'(dok_log.size()), 64'd3);
        if (dok_log.size() >= 3 && acc_log.size() >= 3)
            for (int i = 0; i < 3; i++) chk($sformatf("s5_order_%0d", i), 64'(dok_log[i]), 64'(acc_log[i]));

        // Unexpected response: sticky error, cleared only by reset.
        areset = 1'b1; step(); areset = 1'b0;
        force_dok = 1; step(); force_dok = 0;
        repeat (3) step();
        chk("s6_err_sticky", err_unexp, 1'b1);
        areset = 1'b1; step(); areset = 1'b0;
        chk("s6_err_cleared", err_unexp, 1'b0);

        // Random traffic with mid-transaction resets.
        p_req = 60; p_aok = 50; p_dok = 70; lat_min = 1; lat_max = 4;
        for (int blk = 0; blk < 4; blk++) begin
            i_left = 100000; d_left = 100000;
            repeat (500) step();
            areset = 1'b1; step(); areset = 1'b0;
        end
        p_req = 0; i_left = 0; d_left = 0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
